// File: rtl/cache_fill_unit.sv
// cache_fill_unit: single-outstanding line-fill engine between a cache and its memory arbiter.
// Optional critical-word-first ordering is enabled with `define CACHE_FILL_CRIT_WORD_EN.
module cache_fill_unit #(
  parameter int unsigned          WIDTH      = 64,
  parameter int unsigned          TAG_WIDTH  = 13,
  parameter int unsigned          LINE_BEATS = 8,
  parameter logic [TAG_WIDTH-2:0] TAG_ID     = 12'h001
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_miss_valid,
  input  logic [WIDTH-1:0]            i_miss_addr,
  output logic                        o_miss_ready,
  output logic                        o_reqcyc,
  output logic [WIDTH-1:0]            o_req,
  output logic [TAG_WIDTH-1:0]        o_reqtag,
  input  logic                        i_reqack,
  input  logic                        i_respcyc,
  input  logic [WIDTH-1:0]            i_resp,
  input  logic [TAG_WIDTH-1:0]        i_resptag,
  output logic                        o_respack,
  output logic                        o_fill_valid,
  output logic [WIDTH-1:0]            o_fill_addr,
  output logic [WIDTH*LINE_BEATS-1:0] o_fill_data,
  input  logic                        i_fill_ready,
  output logic                        o_busy
);

  localparam int unsigned WORD_BITS = $clog2(WIDTH / 8);
  localparam int unsigned OFF       = $clog2((WIDTH / 8) * LINE_BEATS);
  localparam int unsigned CNT_W     = $clog2(LINE_BEATS);
  localparam logic [TAG_WIDTH-1:0] REQ_TAG  = {1'b1, TAG_ID};
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_FILL
  } state_t;

  state_t                      r_state;
  logic                        r_miss_ready;
  logic                        r_reqcyc;
  logic [WIDTH-1:0]            r_req;
  logic [TAG_WIDTH-1:0]        r_reqtag;
  logic [WIDTH-1:0]            r_line_addr;
  logic                        r_fill_valid;
  logic [WIDTH-1:0]            r_fill_addr;
  logic [WIDTH*LINE_BEATS-1:0] r_fill_data;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_busy;

  logic [WIDTH-1:0]            w_line_addr;
  logic [WIDTH-1:0]            w_req_addr;
  logic [CNT_W-1:0]            w_lane;
  logic                        w_beat_acc;
  logic                        w_unused_addr;

  assign w_line_addr   = {i_miss_addr[WIDTH-1:OFF], {OFF{1'b0}}};
  // low address bits only select the critical word, and only when that ordering is enabled
  assign w_unused_addr = &{1'b0, i_miss_addr[OFF-1:0]};

`ifdef CACHE_FILL_CRIT_WORD_EN
  logic [CNT_W-1:0] r_start_word;
  logic [CNT_W-1:0] w_start_word;

  assign w_start_word = i_miss_addr[OFF-1:WORD_BITS];
  assign w_req_addr   = {i_miss_addr[WIDTH-1:WORD_BITS], {WORD_BITS{1'b0}}};
  assign w_lane       = r_start_word + r_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_start_word <= '0;
    end else if (r_state == S_IDLE && i_miss_valid) begin
      r_start_word <= w_start_word;
    end
  end
`else
  assign w_req_addr = w_line_addr;
  assign w_lane     = r_cnt;
`endif

  // respack must answer in the same cycle as the beat, so it is decoded rather than registered
  assign w_beat_acc = (r_state == S_RESP) && i_respcyc && (i_resptag == REQ_TAG);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_miss_ready <= 1'b1;
      r_reqcyc     <= 1'b0;
      r_req        <= '0;
      r_reqtag     <= '0;
      r_line_addr  <= '0;
      r_fill_valid <= 1'b0;
      r_fill_addr  <= '0;
      r_fill_data  <= '0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_miss_valid) begin
            r_state      <= S_REQ;
            r_miss_ready <= 1'b0;
            r_busy       <= 1'b1;
            r_line_addr  <= w_line_addr;
            r_reqcyc     <= 1'b1;
            r_req        <= w_req_addr;
            r_reqtag     <= REQ_TAG;
          end
        end
        S_REQ: begin
          if (i_reqack) begin
            r_state  <= S_RESP;
            r_reqcyc <= 1'b0;
            r_req    <= '0;
            r_reqtag <= '0;
            r_cnt    <= '0;
          end
        end
        S_RESP: begin
          if (w_beat_acc) begin
            for (int i = 0; i < LINE_BEATS; i++) begin
              if (w_lane == CNT_W'(i)) begin
                r_fill_data[i*WIDTH +: WIDTH] <= i_resp;
              end
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_CNT) begin
              r_state      <= S_FILL;
              r_fill_valid <= 1'b1;
              r_fill_addr  <= r_line_addr;
            end
          end
        end
        S_FILL: begin
          if (i_fill_ready) begin
            r_state      <= S_IDLE;
            r_fill_valid <= 1'b0;
            r_miss_ready <= 1'b1;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_miss_ready = r_miss_ready;
  assign o_reqcyc     = r_reqcyc;
  assign o_req        = r_req;
  assign o_reqtag     = r_reqtag;
  assign o_respack    = w_beat_acc;
  assign o_fill_valid = r_fill_valid;
  assign o_fill_addr  = r_fill_addr;
  assign o_fill_data  = r_fill_data;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_cache_fill_unit.sv
// Self-checking bench for cache_fill_unit: directed table, reset/corner sequences, randomized fills.
module tb_cache_fill_unit;

  localparam int unsigned W  = 64;
  localparam int unsigned TW = 13;
  localparam int unsigned LB = 8;
  localparam int unsigned LW = W * LB;
`ifdef CACHE_FILL_CRIT_WORD_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif
  localparam logic [TW-1:0] MY_TAG    = 13'h1001;
  localparam logic [TW-1:0] OTHER_TAG = 13'h1002;

  logic          clk;
  logic          reset;
  logic          miss_valid;
  logic [W-1:0]  miss_addr;
  logic          o_miss_ready;
  logic          o_reqcyc;
  logic [W-1:0]  o_req;
  logic [TW-1:0] o_reqtag;
  logic          reqack;
  logic          respcyc;
  logic [W-1:0]  resp;
  logic [TW-1:0] resptag;
  logic          o_respack;
  logic          o_fill_valid;
  logic [W-1:0]  o_fill_addr;
  logic [LW-1:0] o_fill_data;
  logic          fill_ready;
  logic          o_busy;

  int n_pass  = 0;
  int n_total = 0;
  logic [W-1:0] beat_data [LB];

  typedef struct {
    logic [W-1:0] addr;
    int           ack_dly;
    int           stall;
    int           mode;
    logic [W-1:0] base;
    logic [W-1:0] exp_req;
    logic [W-1:0] exp_faddr;
  } vec_t;

  vec_t vt [4];

  cache_fill_unit dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_miss_valid (miss_valid),
    .i_miss_addr  (miss_addr),
    .o_miss_ready (o_miss_ready),
    .o_reqcyc     (o_reqcyc),
    .o_req        (o_req),
    .o_reqtag     (o_reqtag),
    .i_reqack     (reqack),
    .i_respcyc    (respcyc),
    .i_resp       (resp),
    .i_resptag    (resptag),
    .o_respack    (o_respack),
    .o_fill_valid (o_fill_valid),
    .o_fill_addr  (o_fill_addr),
    .o_fill_data  (o_fill_data),
    .i_fill_ready (fill_ready),
    .o_busy       (o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_line(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: line address clears the 64-byte offset; request keeps the word offset when critical-word is on.
  function automatic logic [W-1:0] m_line(input logic [W-1:0] a);
    return a & ~64'h3F;
  endfunction

  function automatic logic [W-1:0] m_req(input logic [W-1:0] a);
    return CRIT ? (a & ~64'h7) : m_line(a);
  endfunction

  function automatic int m_start(input logic [W-1:0] a);
    return CRIT ? int'((a / 8) % 8) : 0;
  endfunction

  // mode 0: back-to-back good beats; mode 1: random idles and foreign-tag beats interleaved
  task automatic run_fill(input logic [W-1:0] addr, input int ack_dly, input int stall, input int mode,
                          input logic [W-1:0] exp_req, input logic [W-1:0] exp_faddr);
    logic [LW-1:0] exp_line;
    int start, got, cyc, kind;
    exp_line = '0;
    start = m_start(addr);

    tick();
    miss_valid = 1'b1;
    miss_addr  = addr;
    samp();
    chk("miss_ready_idle", 64'(o_miss_ready), 64'd1);
    chk("reqcyc_idle", 64'(o_reqcyc), 64'd0);

    tick();
    miss_valid = 1'b0;
    miss_addr  = {$urandom, $urandom};
    for (int d = 0; d <= ack_dly; d++) begin
      if (d > 0) tick();
      reqack  = (d == ack_dly);
      respcyc = (d % 2 == 1);
      resptag = MY_TAG;
      resp    = 64'hBAD0_BAD0_BAD0_BAD0;
      samp();
      chk("reqcyc_req", 64'(o_reqcyc), 64'd1);
      chk("req_addr", o_req, exp_req);
      chk("reqtag", 64'(o_reqtag), 64'(MY_TAG));
      chk("respack_in_req", 64'(o_respack), 64'd0);
      chk("miss_ready_req", 64'(o_miss_ready), 64'd0);
      chk("busy_req", 64'(o_busy), 64'd1);
    end

    tick();
    reqack = 1'b0;
    got = 0;
    cyc = 0;
    while (got < LB && cyc < 200) begin
      if (cyc > 0) tick();
      kind    = (mode == 0) ? 2 : $urandom_range(0, 3);
      respcyc = (kind != 0);
      resptag = (kind == 1) ? OTHER_TAG : MY_TAG;
      resp    = (kind >= 2) ? beat_data[got] : {$urandom, $urandom};
      samp();
      if (cyc == 0) chk("reqcyc_drop", 64'(o_reqcyc), 64'd0);
      chk("respack", 64'(o_respack), 64'(kind >= 2));
      chk("fill_valid_early", 64'(o_fill_valid), 64'd0);
      if (kind >= 2) begin
        exp_line[((start + got) % LB) * W +: W] = beat_data[got];
        got++;
      end
      cyc++;
    end
    if (got < LB) chk("beat_budget", 64'(got), 64'(LB));

    tick();
    respcyc    = 1'b0;
    miss_valid = (stall > 0);
    miss_addr  = {$urandom, $urandom};
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) tick();
      fill_ready = (s == stall);
      samp();
      chk("fill_valid", 64'(o_fill_valid), 64'd1);
      chk("fill_addr", o_fill_addr, exp_faddr);
      chk_line("fill_data", o_fill_data, exp_line);
      chk("miss_ready_fill", 64'(o_miss_ready), 64'd0);
      chk("reqcyc_fill", 64'(o_reqcyc), 64'd0);
    end

    tick();
    fill_ready = 1'b0;
    miss_valid = 1'b0;
    samp();
    chk("fill_valid_done", 64'(o_fill_valid), 64'd0);
    chk("miss_ready_done", 64'(o_miss_ready), 64'd1);
    chk("busy_done", 64'(o_busy), 64'd0);
  endtask

  initial begin
    reset      = 1'b1;
    miss_valid = 1'b0;
    miss_addr  = '0;
    reqack     = 1'b0;
    respcyc    = 1'b0;
    resp       = '0;
    resptag    = '0;
    fill_ready = 1'b0;

    vt[0] = '{64'h1048, 2, 0, 0, 64'h10, (CRIT ? 64'h1048 : 64'h1040), 64'h1040};
    vt[1] = '{64'h1068, 0, 5, 0, 64'hA0, (CRIT ? 64'h1068 : 64'h1040), 64'h1040};
    vt[2] = '{64'h2000, 10, 0, 1, 64'h30, 64'h2000, 64'h2000};
    vt[3] = '{64'hFFFF_FFFF_FFFF_FFF8, 1, 2, 1, 64'h70,
              (CRIT ? 64'hFFFF_FFFF_FFFF_FFF8 : 64'hFFFF_FFFF_FFFF_FFC0), 64'hFFFF_FFFF_FFFF_FFC0};

    repeat (2) @(posedge clk);
    samp();
    chk("rst_miss_ready", 64'(o_miss_ready), 64'd1);
    chk("rst_reqcyc", 64'(o_reqcyc), 64'd0);
    chk("rst_req", o_req, 64'd0);
    chk("rst_fill_valid", 64'(o_fill_valid), 64'd0);
    chk_line("rst_fill_data", o_fill_data, '0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    tick();
    reset = 1'b0;

    // reset arriving mid-RESP after three accepted beats
    tick();
    miss_valid = 1'b1;
    miss_addr  = 64'h3010;
    samp();
    tick();
    miss_valid = 1'b0;
    reqack     = 1'b1;
    samp();
    chk("mid_req", o_req, m_req(64'h3010));
    tick();
    reqack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      respcyc = 1'b1;
      resptag = MY_TAG;
      resp    = 64'h55 + 64'(k);
      samp();
      chk("mid_respack", 64'(o_respack), 64'd1);
    end
    #2;
    reset = 1'b1;
    #1;
    chk("arst_respack", 64'(o_respack), 64'd0);
    chk("arst_busy", 64'(o_busy), 64'd0);
    chk("arst_reqtag", 64'(o_reqtag), 64'd0);
    chk("arst_fill_addr", o_fill_addr, 64'd0);
    chk_line("arst_fill_data", o_fill_data, '0);
    chk("arst_miss_ready", 64'(o_miss_ready), 64'd1);
    tick();
    reset   = 1'b0;
    respcyc = 1'b0;
    samp();
    chk("post_rst_idle", 64'(o_miss_ready), 64'd1);

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < LB; i++) beat_data[i] = vt[v].base + 64'(i);
      run_fill(vt[v].addr, vt[v].ack_dly, vt[v].stall, vt[v].mode, vt[v].exp_req, vt[v].exp_faddr);
    end

    for (int r = 0; r < 20; r++) begin
      logic [W-1:0] a;
      a = {$urandom, $urandom};
      for (int i = 0; i < LB; i++) beat_data[i] = {$urandom, $urandom};
      run_fill(a, $urandom_range(0, 4), $urandom_range(0, 3), 1, m_req(a), m_line(a));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
